// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debounce stage.
package sw_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned CLK_HZ                  = 50000000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, STABLE/SETTLING filter FSM and
// stability counter. chg_o is high at the edge where db_o is about to toggle.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic db_o,
    output logic chg_o
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("debounce_bit: DEBOUNCE_CYCLES must be at least 2");
    end

    logic             meta_q;
    logic             sync_q;
    logic             db_q;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;

    assign differ = sync_q ^ db_q;

    // NOTE: every register here uses <= so all flops sample pre-edge values
    // together; a blocking = would let sync_q see this edge's meta_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            db_q    <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
            unique case (state_q)
                STABLE: begin
                    if (differ) begin
                        state_q <= SETTLING;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                SETTLING: begin
                    if (!differ) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        db_q    <= sync_q;
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Counter ends at CNT_LAST and is cleared on acceptance, so it never wraps.
    assign chg_o = (state_q == SETTLING) && differ && (cnt_q == CNT_LAST);
    assign db_o  = db_q;

endmodule

// File: rtl/sw_debounce.sv
// N-bit slide-switch debouncer feeding the vote logic. Defining
// SW_DEBOUNCE_EDGE_EN adds per-bit SW_RISE/SW_FALL pulses aligned with SW_CHG.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned N               = 5,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic [N-1:0] SW,
    output logic [N-1:0] SW_DB,
    output logic         SW_CHG
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [N-1:0] SW_RISE,
    output logic [N-1:0] SW_FALL
`endif
);

    logic [N-1:0] db;
    logic [N-1:0] bit_chg;
    logic         chg_d;
    logic         chg_q;

    for (genvar i = 0; i < N; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (CLOCK_50),
            .rst_n (RESET_N),
            .sw_i  (SW[i]),
            .db_o  (db[i]),
            .chg_o (bit_chg[i])
        );
    end

    // Several bits accepting together collapse into one pulse.
    assign chg_d = |bit_chg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign SW_DB  = db;
    assign SW_CHG = chg_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [N-1:0] rise_q;
    logic [N-1:0] fall_q;

    // db still holds the pre-toggle level, so it gives the edge direction.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= bit_chg & ~db;
            fall_q <= bit_chg & db;
        end
    end

    assign SW_RISE = rise_q;
    assign SW_FALL = fall_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with N=5, DEBOUNCE_CYCLES=8 (10-edge latency).
module tb_sw_debounce;

    localparam int N  = 5;
    localparam int DC = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw;
    logic [N-1:0] sw_db;
    logic         sw_chg;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
`endif

    int total   = 0;
    int bad     = 0;
    int chg_cnt = 0;

    sw_debounce #(
        .N               (N),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (sw),
        .SW_DB    (sw_db),
        .SW_CHG   (sw_chg)
`ifdef SW_DEBOUNCE_EDGE_EN
        ,
        .SW_RISE  (sw_rise),
        .SW_FALL  (sw_fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; sample 1 ns after each edge and count SW_CHG highs.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sw_chg === 1'b1) chg_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 5'b11111;

        // 1. Reset holds everything at 0, then release with switches high.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("rst_db", 32'(sw_db), 32'h0);
            check("rst_chg", 32'(sw_chg), 32'h0);
        end
        rst_n   = 1'b1;
        chg_cnt = 0;
        tick(DC + 1);
        check("rel_db_early", 32'(sw_db), 32'h00);
        tick(1);
        check("rel_db", 32'(sw_db), 32'h1f);
        check("rel_chg", 32'(sw_chg), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("rel_rise", 32'(sw_rise), 32'h1f);
`endif
        tick(1);
        check("rel_chg_end", 32'(sw_chg), 32'h0);
        check("rel_chg_cnt", 32'(chg_cnt), 32'd1);

        // Return all switches to 0.
        sw = 5'b00000;
        tick(12);
        check("clr_db", 32'(sw_db), 32'h00);

        // 2. Clean press of SW[0].
        chg_cnt = 0;
        sw      = 5'b00001;
        tick(DC + 1);
        check("press_db_early", 32'(sw_db), 32'h00);
        tick(1);
        check("press_db", 32'(sw_db), 32'h01);
        check("press_chg", 32'(sw_chg), 32'h1);
        tick(3);
        check("press_chg_cnt", 32'(chg_cnt), 32'd1);

        // 3. SW[2] bounces with 3-cycle levels, then holds 1.
        chg_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            sw[2] = (p % 2 == 0);
            tick(3);
            check("bounce_db", 32'(sw_db), 32'h01);
        end
        sw[2] = 1'b1;
        tick(DC + 1);
        check("bounce_db_early", 32'(sw_db), 32'h01);
        tick(1);
        check("bounce_db", 32'(sw_db), 32'h05);
        check("bounce_chg", 32'(sw_chg), 32'h1);
        tick(3);
        check("bounce_chg_cnt", 32'(chg_cnt), 32'd1);

        // 4. SW[3] glitch of 7 cycles is rejected.
        chg_cnt = 0;
        sw[3]   = 1'b1;
        tick(7);
        sw[3] = 1'b0;
        tick(8);
        check("glitch_db", 32'(sw_db), 32'h05);
        tick(8);
        check("glitch_db_late", 32'(sw_db), 32'h05);
        check("glitch_chg_cnt", 32'(chg_cnt), 32'd0);

        // 5. SW[1] and SW[4] rise together.
        chg_cnt = 0;
        sw      = 5'b10111;
        tick(DC + 1);
        check("simul_db_early", 32'(sw_db), 32'h05);
        tick(1);
        check("simul_db", 32'(sw_db), 32'h17);
        check("simul_chg", 32'(sw_chg), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("simul_rise", 32'(sw_rise), 32'h12);
        check("simul_fall", 32'(sw_fall), 32'h00);
`endif
        tick(1);
        check("simul_chg_end", 32'(sw_chg), 32'h0);
        check("simul_chg_cnt", 32'(chg_cnt), 32'd1);

        // Release of SW[0] exercises a falling acceptance.
        chg_cnt = 0;
        sw[0]   = 1'b0;
        tick(DC + 1);
        check("fall_db_early", 32'(sw_db), 32'h17);
        tick(1);
        check("fall_db", 32'(sw_db), 32'h16);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("fall_fall", 32'(sw_fall), 32'h01);
        check("fall_rise", 32'(sw_rise), 32'h00);
`endif
        tick(2);
        check("fall_chg_cnt", 32'(chg_cnt), 32'd1);

        // 6. SW[0] rises, reset pulsed mid-settle.
        chg_cnt = 0;
        sw[0]   = 1'b1;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("midrst_db", 32'(sw_db), 32'h00);
        tick(2);
        check("midrst_chg", 32'(sw_chg), 32'h0);
        rst_n = 1'b1;
        tick(DC + 1);
        check("midrst_db_early", 32'(sw_db), 32'h00);
        tick(1);
        check("midrst_db_reacc", 32'(sw_db), 32'h17);
        check("midrst_chg_pulse", 32'(sw_chg), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("midrst_rise", 32'(sw_rise), 32'h17);
`endif
        tick(2);
        check("midrst_chg_cnt", 32'(chg_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
